// File: rtl/seg_display_scan_pkg.sv
// rtl/seg_display_scan_pkg.sv - symbol codes, converter FSM states and seven-segment glyph table
package seg_display_scan_pkg;

  localparam logic [4:0] SYM_BLANK = 5'h10;
  localparam logic [4:0] SYM_DASH  = 5'h11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_t;

  // Active-high {g,f,e,d,c,b,a}; anything outside the table is dark.
  function automatic logic [6:0] glyph(input logic [4:0] sym);
    logic [6:0] seg;
    seg = 7'h00;
    case (sym)
      5'h00: seg = 7'h3F;
      5'h01: seg = 7'h06;
      5'h02: seg = 7'h5B;
      5'h03: seg = 7'h4F;
      5'h04: seg = 7'h66;
      5'h05: seg = 7'h6D;
      5'h06: seg = 7'h7D;
      5'h07: seg = 7'h07;
      5'h08: seg = 7'h7F;
      5'h09: seg = 7'h6F;
      5'h0A: seg = 7'h77;
      5'h0B: seg = 7'h7C;
      5'h0C: seg = 7'h39;
      5'h0D: seg = 7'h5E;
      5'h0E: seg = 7'h79;
      5'h0F: seg = 7'h71;
      SYM_DASH: seg = 7'h40;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter with overflow flag
module bin2bcd_seq #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sr;
  logic [BW-1:0]     bcd_r;
  logic [BW-1:0]     adj;
  logic [CW-1:0]     cnt;
  logic              busy_r;
  logic              ovf_r;

  always_comb begin
    adj = bcd_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
    end
  end

  // A 1 shifted out of the top digit means the value has reached 10^NUM_DIGITS;
  // doubling only grows it, so the flag is sticky for the rest of the run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr     <= '0;
      bcd_r  <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (!busy_r) begin
      if (start) begin
        sr     <= bin;
        bcd_r  <= '0;
        ovf_r  <= 1'b0;
        cnt    <= CW'(DATA_W);
        busy_r <= 1'b1;
      end
    end else if (cnt != '0) begin
      bcd_r <= {adj[BW-2:0], sr[DATA_W-1]};
      sr    <= sr << 1;
      ovf_r <= ovf_r | adj[BW-1];
      cnt   <= cnt - CW'(1);
    end else begin
      busy_r <= 1'b0;
    end
  end

  assign busy = busy_r;
  assign done = busy_r && (cnt == '0);
  assign bcd  = bcd_r;
  assign ovf  = ovf_r;

endmodule

// File: rtl/seg_display_scan.sv
// rtl/seg_display_scan.sv - multiplexed hex/decimal seven-segment driver with blanking and refresh scan
module seg_display_scan
  import seg_display_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 100000,
  parameter int AN_ACT_LOW  = 1,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_W-1:0]     data,
  input  logic                  dec_mode,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic                  ovf,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [7:0]            catode
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [7:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

  logic [PW-1:0]         presc;
  logic                  tick;
  logic [IW-1:0]         idx;
  conv_state_t           state, next_state;
  logic [BW-1:0]         disp;
  logic [NUM_DIGITS-1:0] dp_reg;
  logic                  ovf_reg;
  logic                  accept, conv_start;
  logic                  conv_busy, conv_done, conv_ovf;
  logic [BW-1:0]         conv_bcd;
  logic                  primed;

  assign tick = (presc == PW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign accept     = load && (state == ST_IDLE) && !conv_busy;
  assign conv_start = accept && dec_mode;

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (data),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (conv_start) next_state = ST_CONV;
      ST_CONV: if (conv_done) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      disp    <= '0;
      dp_reg  <= '0;
      ovf_reg <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) dp_reg <= dp_mask;
      if (accept && !dec_mode) begin
        disp    <= BW'(data);
        ovf_reg <= 1'b0;
      end
      if (state == ST_DONE) begin
        ovf_reg <= conv_ovf;
        if (!conv_ovf) disp <= conv_bcd;
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign ovf  = ovf_reg;

  logic [NUM_DIGITS-1:0] lz;
  logic [NUM_DIGITS-1:0] an_on;
  logic [3:0]            cur_nib;
  logic                  cur_lz, cur_dp;
  logic [4:0]            sym;
  logic [7:0]            lit;

  // lz[i] is set when digit i and every digit above it are zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (disp[4*i +: 4] == 4'd0);
      lz[i]    = zero_run;
    end
  end

  always_comb begin
    cur_nib = 4'd0;
    cur_lz  = 1'b0;
    cur_dp  = 1'b0;
    an_on   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur_nib  = disp[4*i +: 4];
        cur_lz   = lz[i];
        cur_dp   = dp_reg[i];
        an_on[i] = 1'b1;
      end
    end
    if (ovf_reg)                                sym = SYM_DASH;
    else if (blank_lz && cur_lz && idx != '0)   sym = SYM_BLANK;
    else                                        sym = {1'b0, cur_nib};
    lit = {cur_dp, glyph(sym)};
  end

  // primed keeps the pins dark for the first cycle after reset as well.
  always_ff @(posedge clk) begin
    if (!reset) begin
      anode  <= AN_OFF;
      catode <= SEG_OFF;
      primed <= 1'b0;
    end else begin
      primed <= 1'b1;
      if (!primed || tick) anode <= AN_OFF;
      else                 anode <= (AN_ACT_LOW != 0) ? ~an_on : an_on;
      if (!primed)         catode <= SEG_OFF;
      else                 catode <= (SEG_ACT_LOW != 0) ? ~lit : lit;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// tb/tb_seg_display_scan.sv - directed self-checking bench for seg_display_scan
module tb_seg_display_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] data;
  logic        dec_mode;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic        busy;
  logic        ovf;
  logic [3:0]  anode;
  logic [7:0]  catode;

  int total = 0;
  int bad   = 0;

  seg_display_scan #(
    .NUM_DIGITS  (4),
    .DATA_W      (16),
    .REFRESH_DIV (4),
    .AN_ACT_LOW  (1),
    .SEG_ACT_LOW (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data     (data),
    .dec_mode (dec_mode),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .busy     (busy),
    .ovf      (ovf),
    .anode    (anode),
    .catode   (catode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic show_digit(input int i, input logic [7:0] exp, input string tag);
    int n;
    logic [3:0] want;
    want = ~(4'b0001 << i);
    n = 0;
    @(negedge clk);
    while (anode !== want && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_an"}, {28'd0, anode}, {28'd0, want});
    chk(tag, {24'd0, catode}, {24'd0, exp});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_load(input logic [15:0] d, input logic dm, input logic [3:0] dpm);
    data = d; dec_mode = dm; dp_mask = dpm; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Expected pins during k-th cycle after the last reset edge, REFRESH_DIV=4.
  logic [7:0] hex_cat [4] = '{8'h8E, 8'hB0, 8'h88, 8'hF9};

  initial begin
    int n;
    logic [3:0] exp_an;
    reset = 1'b0; load = 1'b0; data = '0; dec_mode = 1'b0; blank_lz = 1'b0; dp_mask = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // 1: reset held 3 cycles mid-scan
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_anode", {28'd0, anode}, 32'hF);
      chk("rst_catode", {24'd0, catode}, 32'hFF);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
    end

    // 2: hex 1A3F loaded on the first cycle out of reset; exact scan pattern
    reset = 1'b1; data = 16'h1A3F; dec_mode = 1'b0; dp_mask = 4'b0000; load = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (k <= 1 || (k % 4) == 0) exp_an = 4'hF;
      else                        exp_an = ~(4'b0001 << ((k / 4) % 4));
      chk("scan_anode", {28'd0, anode}, {28'd0, exp_an});
      if (k <= 1)
        chk("scan_dark", {24'd0, catode}, 32'hFF);
      else if ((k % 4) != 0)
        chk("scan_catode", {24'd0, catode}, {24'd0, hex_cat[(k / 4) % 4]});
    end

    // 3: decimal 1234, busy for DATA_W+2 cycles
    do_load(16'd1234, 1'b1, 4'b0000);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("dec_busy_cycles", n, 32'd18);
    chk("dec_ovf", {31'd0, ovf}, 32'd0);
    show_digit(0, 8'h99, "dec_d0");
    show_digit(1, 8'hB0, "dec_d1");
    show_digit(2, 8'hA4, "dec_d2");
    show_digit(3, 8'hF9, "dec_d3");

    // boundary: 9999 fits, 10000 overflows
    do_load(16'd9999, 1'b1, 4'b0000);
    wait_idle("b9999_idle");
    chk("b9999_ovf", {31'd0, ovf}, 32'd0);
    show_digit(3, 8'h90, "b9999_d3");
    do_load(16'd10000, 1'b1, 4'b0000);
    wait_idle("b10000_idle");
    chk("b10000_ovf", {31'd0, ovf}, 32'd1);
    show_digit(0, 8'hBF, "b10000_d0");

    // 4: 65535 overflows to dashes; hex load clears ovf
    do_load(16'd65535, 1'b1, 4'b0000);
    wait_idle("ovf_idle");
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    show_digit(1, 8'hBF, "ovf_d1");
    show_digit(3, 8'hBF, "ovf_d3");
    do_load(16'h00C0, 1'b0, 4'b0000);
    chk("ovf_clear", {31'd0, ovf}, 32'd0);
    show_digit(1, 8'hC6, "hexc_d1");

    // 5: leading-zero blanking with a decimal point on a blanked digit
    blank_lz = 1'b1;
    do_load(16'h0005, 1'b0, 4'b0100);
    show_digit(3, 8'hFF, "lz_d3");
    show_digit(2, 8'h7F, "lz_d2");
    show_digit(1, 8'hFF, "lz_d1");
    show_digit(0, 8'h92, "lz_d0");
    blank_lz = 1'b0;
    show_digit(3, 8'hC0, "nolz_d3");
    show_digit(2, 8'h40, "nolz_d2");

    // 6a: load during conversion is ignored
    do_load(16'd42, 1'b1, 4'b0000);
    repeat (5) @(negedge clk);
    chk("conv_busy", {31'd0, busy}, 32'd1);
    do_load(16'h7777, 1'b0, 4'b1111);
    wait_idle("ign_idle");
    show_digit(0, 8'hA4, "ign_d0");
    show_digit(1, 8'h99, "ign_d1");
    show_digit(2, 8'hC0, "ign_d2");

    // 6b: reset pulse mid-conversion aborts; display is the reset value
    do_load(16'd99, 1'b1, 4'b0000);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy2", {31'd0, busy}, 32'd0);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    show_digit(0, 8'hC0, "abort_d0");
    show_digit(1, 8'hC0, "abort_d1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
